// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared constants, state encoding and command helper for the SPI memory master
package spi_mem_pkg;

    localparam int MEM_DEPTH = 32;

    localparam logic [2:0] OP_WR  = 3'b001;
    localparam logic [2:0] OP_RD  = 3'b010;
    localparam logic [2:0] OP_BWR = 3'b011;
    localparam logic [2:0] OP_BRD = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_LOAD,
        ST_HOLD,
        ST_GAP,
        ST_ERR
    } state_t;

    function automatic logic [7:0] cmd_byte(input logic [2:0] op, input logic [4:0] addr);
        return {op, addr};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - half-period counter producing SCLK edge strobes
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic load_i,
    input  logic shift_i,
    input  logic sclk_i,
    output logic half_end_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign half_end_o = en_i && (cnt_q == CW'(CLK_DIV - 1));
    assign rise_o     = half_end_o && shift_i && !sclk_i;
    assign fall_o     = half_end_o && shift_i && sclk_i;

    // load_i credits the write-handshake cycle to the low half that follows it
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = CW'(1);
        else if (!en_i || half_end_o)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_mem_master.sv
// rtl/spi_mem_master.sv - SPI mode-0 master for the 32-byte SPI memory slave
module spi_mem_master
    import spi_mem_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int ADDR_W    = 5,
    parameter int MEM_DEPTH = spi_mem_pkg::MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [5:0]        len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    input  logic [7:0]        wr_data_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    output logic [7:0]        rd_data_o,
    output logic              rd_valid_o,
    output logic              cs_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i
);

    state_t      state_q, state_d;
    logic        cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        wr_ready_q, wr_ready_d, rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d, tx_q, tx_d, rx_q, rx_d;
    logic [2:0]  bit_q, bit_d;
    logic [6:0]  left_q, left_d;
    logic        is_wr_q, is_wr_d, is_rd_q, is_rd_d;
    logic        data_q, data_d, trunc_q, trunc_d;

    logic        half_end, rise, fall, gen_en;
    logic        is_burst, legal_op, len_ok;
    logic [6:0]  len_w, room_w, burst_n;
    logic [7:0]  cmd;

    assign gen_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                    (state_q == ST_HOLD)  || (state_q == ST_GAP);

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .en_i       (gen_en),
        .load_i     ((state_q == ST_LOAD) && wr_valid_i),
        .shift_i    (state_q == ST_SHIFT),
        .sclk_i     (sclk_q),
        .half_end_o (half_end),
        .rise_o     (rise),
        .fall_o     (fall)
    );

    assign is_burst = (op_i == OP_BWR) || (op_i == OP_BRD);
    assign legal_op = (op_i == OP_WR) || (op_i == OP_RD) || is_burst;
    assign len_w    = {1'b0, len_i};
    assign len_ok   = (len_i != 6'd0) && (len_w <= 7'(MEM_DEPTH));
    assign room_w   = 7'(MEM_DEPTH) - 7'(addr_i);
    assign burst_n  = (len_w < room_w) ? len_w : room_w;
    assign cmd      = cmd_byte(op_i, addr_i);

    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wr_ready_d = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_d      = bit_q;
        left_d     = left_q;
        is_wr_d    = is_wr_q;
        is_rd_d    = is_rd_q;
        data_d     = data_q;
        trunc_d    = trunc_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !done_q) begin
                    busy_d = 1'b1;
                    if (!legal_op || (is_burst && !len_ok)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_SETUP;
                        cs_d    = 1'b0;
                        mosi_d  = cmd[7];
                        tx_d    = cmd;
                        bit_d   = 3'd0;
                        left_d  = is_burst ? burst_n : 7'd1;
                        trunc_d = is_burst && (len_w > room_w);
                        is_wr_d = (op_i == OP_WR) || (op_i == OP_BWR);
                        is_rd_d = (op_i == OP_RD) || (op_i == OP_BRD);
                        data_d  = 1'b0;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
                busy_d  = 1'b0;
            end
            ST_SETUP: begin
                if (half_end)
                    state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (rise) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[6:0], miso_i};
                    if (bit_q == 3'd7 && data_q && is_rd_q) begin
                        rd_data_d  = {rx_q[6:0], miso_i};
                        rd_valid_d = 1'b1;
                    end
                end
                if (fall) begin
                    sclk_d = 1'b0;
                    bit_d  = bit_q + 3'd1;
                    tx_d   = {tx_q[6:0], 1'b0};
                    mosi_d = tx_q[6];
                    if (bit_q == 3'd7) begin
                        data_d = 1'b1;
                        mosi_d = 1'b0;
                        tx_d   = 8'h00;
                        if (left_q == 7'd0) begin
                            state_d = ST_HOLD;
                        end else begin
                            left_d = left_q - 7'd1;
                            if (is_wr_q) begin
                                state_d    = ST_LOAD;
                                wr_ready_d = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (wr_valid_i) begin
                    state_d = ST_SHIFT;
                    tx_d    = wr_data_i;
                    mosi_d  = wr_data_i[7];
                end else begin
                    wr_ready_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (half_end) begin
                    state_d = ST_GAP;
                    cs_d    = 1'b1;
                end
            end
            ST_GAP: begin
                if (half_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = trunc_q;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            bit_q      <= 3'd0;
            left_q     <= 7'd0;
            is_wr_q    <= 1'b0;
            is_rd_q    <= 1'b0;
            data_q     <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_q      <= bit_d;
            left_q     <= left_d;
            is_wr_q    <= is_wr_d;
            is_rd_q    <= is_rd_d;
            data_q     <= data_d;
            trunc_q    <= trunc_d;
        end
    end

    assign cs_o       = cs_q;
    assign sclk_o     = sclk_q;
    assign mosi_o     = mosi_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign wr_ready_o = wr_ready_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule
